// File: rtl/freq_meter_if.sv
// Control/result bundle for freq_meter: enable and the measured signal go in,
// the published count and its status come out.
interface freq_meter_if #(
   parameter int unsigned CNT_W = 32
);
   logic             enable;
   logic             sig_in;
   logic [CNT_W-1:0] freq;
   logic             valid;
   logic             overflow;
   logic             busy;

   modport master (
      output enable,
      output sig_in,
      input  freq,
      input  valid,
      input  overflow,
      input  busy
   );

   modport slave (
      input  enable,
      input  sig_in,
      output freq,
      output valid,
      output overflow,
      output busy
   );
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous sig_in over a
// fixed window of CLK_FREQ/GATE_HZ iclk cycles and publishes each count with
// a one-cycle valid pulse. Windows run back to back while enable is high.
//
// state   | meaning
// IDLE    | no window running, counters held at zero, edges ignored
// MEASURE | gate window running, gate_cnt advancing, edges counted
module freq_meter #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned GATE_HZ  = 1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic        iclk,
   input  logic        reset,
   freq_meter_if.slave bus
);

   localparam int unsigned      GATE_CYC  = CLK_FREQ / GATE_HZ;
   localparam int unsigned      GATE_W    = $clog2(GATE_CYC);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        sync_q, sync_d;
   logic              edge_det_q, edge_det_d;
   logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic [CNT_W-1:0]  freq_q, freq_d;
   logic              overflow_q, overflow_d;
   logic              valid_q, valid_d;

   logic [CNT_W-1:0]  cnt_upd;
   logic              ovf_upd;

   // Synchronizer shift (sync_q[1] is the safe sample, sync_q[2] its delayed
   // copy) and the registered rising-edge pulse; runs regardless of state.
   always_comb begin
      sync_d     = {sync_q[1:0], bus.sig_in};
      edge_det_d = sync_q[1] & ~sync_q[2];
   end

   // Edge count including this cycle's edge; saturates and flags the overflow.
   always_comb begin
      cnt_upd = edge_cnt_q;
      ovf_upd = ovf_pend_q;
      if (edge_det_q) begin
         if (edge_cnt_q == CNT_MAX) begin
            ovf_upd = 1'b1;
         end else begin
            cnt_upd = edge_cnt_q + 1'b1;
         end
      end
   end

   // Next-state, gate timing and result publication.
   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      ovf_pend_d = ovf_pend_q;
      freq_d     = freq_q;
      overflow_d = overflow_q;
      valid_d    = 1'b0;

      case (state_q)
         IDLE: begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_pend_d = 1'b0;
            if (bus.enable) begin
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (!bus.enable) begin
               // Abort drops the partial window; the last result stays visible.
               state_d    = IDLE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               ovf_pend_d = 1'b0;
            end else if (gate_cnt_q == GATE_LAST) begin
               // Last gate cycle: publish and wrap with no gap cycle.
               freq_d     = cnt_upd;
               overflow_d = ovf_upd;
               valid_d    = 1'b1;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               ovf_pend_d = 1'b0;
            end else begin
               gate_cnt_d = gate_cnt_q + 1'b1;
               edge_cnt_d = cnt_upd;
               ovf_pend_d = ovf_upd;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared by the asynchronous reset.
   always_ff @(posedge iclk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sync_q     <= '0;
         edge_det_q <= 1'b0;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         ovf_pend_q <= 1'b0;
         freq_q     <= '0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         edge_det_q <= edge_det_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_pend_q <= ovf_pend_d;
         freq_q     <= freq_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.freq     = freq_q;
   assign bus.overflow = overflow_q;
   assign bus.valid    = valid_q;
   assign bus.busy     = (state_q == MEASURE);

endmodule
